// File: rtl/arith_ctrl_pkg.sv
// arith_ctrl_pkg: shared encodings for the arithmetic micro-sequencer.
// ARITH_CTRL_MUL_EN (optional define) makes op_kind 3 (MUL) legal.
package arith_ctrl_pkg;

   localparam int MUL_STEPS = 30;   // multiply iterations, one per word bit
   localparam int CNT_W     = 5;    // iteration counter width

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_MUL = 3'd3
   } op_kind_e;

   localparam logic [1:0] SEL_ADDR1 = 2'd0;
   localparam logic [1:0] SEL_ADDR2 = 2'd1;

   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_RD1, S_MV_A, S_RD2, S_MV_B, S_NOT_B,
      S_SUM, S_MV_C, S_ANDS, S_TEST, S_SHIFT, S_WR, S_DONE
   } state_e;

   // Registered control pulses; rd/wr_issue arm the memory port one
   // cycle ahead so the request is up in the first cycle of RD/WR.
   typedef struct packed {
      logic clr_a;
      logic clr_b;
      logic clr_c;
      logic not_b;
      logic sum;
      logic and_op;
      logic c_to_a;
      logic c_to_b;
      logic b_to_c;
      logic rd_issue;
      logic wr_issue;
      logic done;
   } ctl_t;

   function automatic logic op_legal(input logic [2:0] k);
`ifdef ARITH_CTRL_MUL_EN
      return (k <= 3'd3);
`else
      return (k <= 3'd2);
`endif
   endfunction

   // Pulses active while sitting in state s
   function automatic ctl_t decode(input state_e s);
      ctl_t c;
      c = '0;
      case (s)
         S_CLR:   begin c.clr_a = 1'b1; c.clr_b = 1'b1; c.clr_c = 1'b1; c.rd_issue = 1'b1; end
         S_MV_A:  begin c.c_to_a = 1'b1; c.rd_issue = 1'b1; end
         S_MV_B:  c.c_to_b = 1'b1;
         S_NOT_B: c.not_b = 1'b1;
         S_SUM:   c.sum = 1'b1;
         S_MV_C:  begin c.b_to_c = 1'b1; c.wr_issue = 1'b1; end
         S_ANDS:  begin c.and_op = 1'b1; c.wr_issue = 1'b1; end
         S_DONE:  c.done = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/arith_ctrl_mem_port.sv
// arith_ctrl_mem_port: holds read/write requests until ack and turns the
// ack into one-cycle completion pulses. Read data is valid in the ack
// cycle, so do_mem_to_c fires combinationally in that same cycle.
module arith_ctrl_mem_port (
   input  logic clk,
   input  logic reset,
   input  logic rd_issue,
   input  logic wr_issue,
   input  logic mem_ack,
   output logic mem_rd_req,
   output logic mem_wr_req,
   output logic rd_done,
   output logic wr_done,
   output logic do_mem_to_c
);

   // Request flops: set by the sequencer, dropped on ack or reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rd_req <= 1'b0;
         mem_wr_req <= 1'b0;
      end else begin
         if (rd_issue)     mem_rd_req <= 1'b1;
         else if (mem_ack) mem_rd_req <= 1'b0;
         if (wr_issue)     mem_wr_req <= 1'b1;
         else if (mem_ack) mem_wr_req <= 1'b0;
      end
   end

   // An ack with no request outstanding produces nothing
   assign rd_done     = mem_rd_req & mem_ack;
   assign wr_done     = mem_wr_req & mem_ack;
   assign do_mem_to_c = rd_done;

endmodule

// File: rtl/arith_ctrl.sv
// arith_ctrl: micro-sequencer in front of the arithmetic unit. Fetches two
// operands, sequences ADD/SUB/AND/MUL pulses, writes the result to addr2.
// Define ARITH_CTRL_MUL_EN to include the 30-step shift-add MUL path.
module arith_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_from_op,
   input  logic [2:0] op_kind_from_op,
   output logic       busy_to_op,
   output logic       done_to_op,
   output logic       flag_to_op,
   output logic       err_to_op,
   output logic       mem_rd_req_to_mem,
   output logic       mem_wr_req_to_mem,
   input  logic       mem_ack_from_mem,
   output logic [1:0] addr_sel_to_sel,
   input  logic       carry_out_from_au,
   input  logic       reg_c30_from_au,
   output logic       do_clear_a_to_au,
   output logic       do_clear_b_to_au,
   output logic       do_clear_c_to_au,
   output logic       do_not_b_to_au,
   output logic       do_sum_to_au,
   output logic       do_and_to_au,
   output logic       do_move_c_to_a_to_au,
   output logic       do_move_c_to_b_to_au,
   output logic       do_move_b_to_c_to_au,
   output logic       do_right_shift_bc_to_au,
   output logic       do_mem_to_c_to_au
);
   import arith_ctrl_pkg::*;

   state_e   state, state_n;
   op_kind_e op_q;
   ctl_t     ctl;
   logic     rd_done, wr_done, last_step;

   arith_ctrl_mem_port u_mem_port (
      .clk         (clk),
      .reset       (reset),
      .rd_issue    (ctl.rd_issue),
      .wr_issue    (ctl.wr_issue),
      .mem_ack     (mem_ack_from_mem),
      .mem_rd_req  (mem_rd_req_to_mem),
      .mem_wr_req  (mem_wr_req_to_mem),
      .rd_done     (rd_done),
      .wr_done     (wr_done),
      .do_mem_to_c (do_mem_to_c_to_au)
   );

   // Next-state selection per operation path
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start_from_op && op_legal(op_kind_from_op)) state_n = S_CLR;
         S_CLR:   state_n = S_RD1;
         S_RD1:   if (rd_done) state_n = S_MV_A;
         S_MV_A:  state_n = S_RD2;
         S_RD2:   if (rd_done) begin
                     if (op_q == OP_AND)      state_n = S_ANDS;
                     else if (op_q == OP_MUL) state_n = S_TEST;
                     else                     state_n = S_MV_B;
                  end
         S_MV_B:  state_n = (op_q == OP_SUB) ? S_NOT_B : S_SUM;
         S_NOT_B: state_n = S_SUM;
         S_SUM:   state_n = S_MV_C;
         S_TEST:  state_n = S_SHIFT;
         S_SHIFT: state_n = last_step ? S_MV_C : S_TEST;
         S_MV_C:  state_n = S_WR;
         S_ANDS:  state_n = S_WR;
         S_WR:    if (wr_done) state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Sequencer state plus registered pulses decoded from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         op_q            <= OP_ADD;
         ctl             <= '0;
         addr_sel_to_sel <= SEL_ADDR1;
         flag_to_op      <= 1'b0;
         err_to_op       <= 1'b0;
      end else begin
         state     <= state_n;
         ctl       <= decode(state_n);
         err_to_op <= (state == S_IDLE) && start_from_op && !op_legal(op_kind_from_op);
         if (state == S_IDLE && start_from_op)
            op_q <= op_kind_e'(op_kind_from_op);
         if (state_n == S_RD1)
            addr_sel_to_sel <= SEL_ADDR1;
         else if (state_n == S_RD2 || state_n == S_WR)
            addr_sel_to_sel <= SEL_ADDR2;
         // carry_out is sampled before the sum lands in B
         if (state_n == S_CLR)
            flag_to_op <= 1'b0;
         else if (state == S_SUM)
            flag_to_op <= (op_q == OP_SUB) ? ~carry_out_from_au : carry_out_from_au;
      end
   end

`ifdef ARITH_CTRL_MUL_EN
   logic [CNT_W-1:0] cnt;
   logic             shift_q;

   // MUL iteration counter and registered shift pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         shift_q <= 1'b0;
      end else begin
         shift_q <= (state_n == S_SHIFT);
         if (state == S_SHIFT)
            cnt <= last_step ? '0 : cnt + 1'b1;
      end
   end

   assign last_step               = (cnt == CNT_W'(MUL_STEPS - 1));
   assign do_right_shift_bc_to_au = shift_q;
`else
   assign last_step               = 1'b1;
   assign do_right_shift_bc_to_au = 1'b0;
`endif

   assign busy_to_op           = (state != S_IDLE);
   assign done_to_op           = ctl.done;
   assign do_clear_a_to_au     = ctl.clr_a;
   assign do_clear_b_to_au     = ctl.clr_b;
   assign do_clear_c_to_au     = ctl.clr_c;
   assign do_not_b_to_au       = ctl.not_b;
   // In TEST the add depends on the multiplier bit just loaded into C,
   // which only becomes visible in that cycle, so it is gated live.
   assign do_sum_to_au         = ctl.sum | ((state == S_TEST) & reg_c30_from_au);
   assign do_and_to_au         = ctl.and_op;
   assign do_move_c_to_a_to_au = ctl.c_to_a;
   assign do_move_c_to_b_to_au = ctl.c_to_b;
   assign do_move_b_to_c_to_au = ctl.b_to_c;

endmodule

// File: tb/tb_arith_ctrl.sv
// tb_arith_ctrl: drives arith_ctrl against a behavioural arithmetic unit and
// memory; expected write data goes to a scoreboard queue at start time.
module tb_arith_ctrl;

   typedef struct {
      logic [2:0]  op;
      logic [29:0] a;
      logic [29:0] b;
      logic [29:0] res;
      logic        flag;
      int          lat;
      int          dly;
      int          poke;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_from_op;
   logic [2:0]  op_kind_from_op;
   logic        busy_to_op, done_to_op, flag_to_op, err_to_op;
   logic        mem_rd_req_to_mem, mem_wr_req_to_mem, mem_ack_from_mem;
   logic [1:0]  addr_sel_to_sel;
   logic        carry_out_from_au, reg_c30_from_au;
   logic        do_clear_a_to_au, do_clear_b_to_au, do_clear_c_to_au, do_not_b_to_au;
   logic        do_sum_to_au, do_and_to_au, do_move_c_to_a_to_au, do_move_c_to_b_to_au;
   logic        do_move_b_to_c_to_au, do_right_shift_bc_to_au, do_mem_to_c_to_au;

   int          passed = 0;
   int          total  = 0;
   int          shifts = 0;
   int          hold_err = 0;
   int          ack_dly = 0;
   int          wcnt = 0;
   logic        stray_ack = 1'b0;
   logic [29:0] op1 = '0, op2 = '0;
   logic [29:0] exp_q[$];

   // behavioural arithmetic unit
   logic [29:0] ra = '0, rb = '0, rc = '0;
   logic        cin = 1'b0, cy = 1'b0;
   logic [30:0] sum_w;
   logic [18:0] all_outs;

   always #5 clk = ~clk;

   arith_ctrl dut (
      .clk                     (clk),
      .reset                   (reset),
      .start_from_op           (start_from_op),
      .op_kind_from_op         (op_kind_from_op),
      .busy_to_op              (busy_to_op),
      .done_to_op              (done_to_op),
      .flag_to_op              (flag_to_op),
      .err_to_op               (err_to_op),
      .mem_rd_req_to_mem       (mem_rd_req_to_mem),
      .mem_wr_req_to_mem       (mem_wr_req_to_mem),
      .mem_ack_from_mem        (mem_ack_from_mem),
      .addr_sel_to_sel         (addr_sel_to_sel),
      .carry_out_from_au       (carry_out_from_au),
      .reg_c30_from_au         (reg_c30_from_au),
      .do_clear_a_to_au        (do_clear_a_to_au),
      .do_clear_b_to_au        (do_clear_b_to_au),
      .do_clear_c_to_au        (do_clear_c_to_au),
      .do_not_b_to_au          (do_not_b_to_au),
      .do_sum_to_au            (do_sum_to_au),
      .do_and_to_au            (do_and_to_au),
      .do_move_c_to_a_to_au    (do_move_c_to_a_to_au),
      .do_move_c_to_b_to_au    (do_move_c_to_b_to_au),
      .do_move_b_to_c_to_au    (do_move_b_to_c_to_au),
      .do_right_shift_bc_to_au (do_right_shift_bc_to_au),
      .do_mem_to_c_to_au       (do_mem_to_c_to_au)
   );

   assign all_outs = {busy_to_op, done_to_op, flag_to_op, err_to_op, mem_rd_req_to_mem,
                      mem_wr_req_to_mem, addr_sel_to_sel, do_clear_a_to_au, do_clear_b_to_au,
                      do_clear_c_to_au, do_not_b_to_au, do_sum_to_au, do_and_to_au,
                      do_move_c_to_a_to_au, do_move_c_to_b_to_au, do_move_b_to_c_to_au,
                      do_right_shift_bc_to_au, do_mem_to_c_to_au};

   assign sum_w             = {1'b0, ra} + {1'b0, rb} + {30'd0, cin};
   assign carry_out_from_au = sum_w[30];
   assign reg_c30_from_au   = rc[0];
   assign mem_ack_from_mem  = (((mem_rd_req_to_mem | mem_wr_req_to_mem) && (wcnt == ack_dly)) || stray_ack);

   always @(posedge clk) begin
      if (do_clear_a_to_au) ra <= '0;
      if (do_clear_b_to_au) begin rb <= '0; cin <= 1'b0; cy <= 1'b0; end
      if (do_clear_c_to_au) rc <= '0;
      if (do_not_b_to_au) begin rb <= ~rb; cin <= 1'b1; end
      if (do_sum_to_au) begin rb <= sum_w[29:0]; cy <= sum_w[30]; end
      if (do_and_to_au) rc <= ra & rc;
      if (do_move_c_to_a_to_au) ra <= rc;
      if (do_move_c_to_b_to_au) rb <= rc;
      if (do_move_b_to_c_to_au) rc <= rb;
      if (do_right_shift_bc_to_au) begin rb <= {cy, rb[29:1]}; rc <= {rb[0], rc[29:1]}; cy <= 1'b0; end
      if (do_mem_to_c_to_au) rc <= (addr_sel_to_sel == 2'd0) ? op1 : op2;
   end

   // memory wait-state counter
   always @(posedge clk) begin
      if ((mem_rd_req_to_mem | mem_wr_req_to_mem) && !mem_ack_from_mem) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h", nm, act, req);
   endtask

   task automatic bad(input string nm);
      total++;
      $display("FAIL %s: got no event within bound, required event", nm);
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [29:0] a, input logic [29:0] b,
                               input logic [29:0] res, input logic flag, input int lat,
                               input int dly, input int poke);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.flag = flag;
      v.lat = lat; v.dly = dly; v.poke = poke;
      return v;
   endfunction

   // write monitor: pops the scoreboard, counts shifts, watches request hold
   initial begin
      logic pr, pw, pa;
      pr = 1'b0; pw = 1'b0; pa = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (do_right_shift_bc_to_au) shifts++;
            if ((pr && !pa && !mem_rd_req_to_mem) || (pw && !pa && !mem_wr_req_to_mem)) hold_err++;
            if (mem_wr_req_to_mem && mem_ack_from_mem) begin
               if (exp_q.size() == 0) bad("wr_unexpected");
               else chk("wr_data", 32'(rc), 32'(exp_q.pop_front()));
               chk("wr_sel", 32'(addr_sel_to_sel), 32'd1);
            end
         end
         pr = mem_rd_req_to_mem & ~reset;
         pw = mem_wr_req_to_mem & ~reset;
         pa = mem_ack_from_mem;
      end
   end

   // one complete command, entered and left on a falling edge
   task automatic run_op(input vec_t v);
      int cyc, sh0, he0;
      bit got;
      ack_dly = v.dly; op1 = v.a; op2 = v.b;
      sh0 = shifts; he0 = hold_err;
      exp_q.push_back(v.res);
      op_kind_from_op = v.op;
      start_from_op = 1'b1;
      cyc = 0; got = 0;
      while (cyc < 300 && !got) begin
         @(negedge clk);
         cyc++;
         start_from_op = (cyc == v.poke);
         if (done_to_op) got = 1;
      end
      start_from_op = 1'b0;
      if (!got) bad("done_timeout");
      else begin
         chk("latency", 32'(cyc), 32'(v.lat));
         chk("flag", 32'(flag_to_op), 32'(v.flag));
      end
      chk("wr_seen", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      chk("req_held", 32'(hold_err - he0), 32'd0);
      if (v.op == 3'd3) chk("mul_shifts", 32'(shifts - sh0), 32'd30);
      @(negedge clk);
      chk("done_one_cycle", 32'(done_to_op), 32'd0);
      chk("idle_after", 32'(busy_to_op), 32'd0);
      chk("flag_hold", 32'(flag_to_op), 32'(v.flag));
      @(negedge clk);
      chk("still_idle", 32'(busy_to_op), 32'd0);
   endtask

   task automatic run_illegal(input logic [2:0] op);
      op_kind_from_op = op;
      start_from_op = 1'b1;
      @(negedge clk);
      start_from_op = 1'b0;
      chk("err_pulse", 32'(err_to_op), 32'd1);
      chk("err_busy", 32'(busy_to_op), 32'd0);
      @(negedge clk);
      chk("err_one_cycle", 32'(err_to_op), 32'd0);
      chk("err_stay_idle", 32'(busy_to_op), 32'd0);
   endtask

   initial begin
      vec_t vt[$];
      int n;
      vt.push_back(mk(3'd0, 30'd5,          30'd3,          30'd8,          1'b0, 9,  0, 0));
      vt.push_back(mk(3'd0, 30'h3FFFFFFF,   30'h00000001,   30'h00000000,   1'b1, 9,  0, 0));
      vt.push_back(mk(3'd1, 30'd3,          30'd5,          30'h3FFFFFFE,   1'b1, 10, 0, 0));
      vt.push_back(mk(3'd2, 30'h0F0F0F0F,   30'h00FF00FF,   30'h000F000F,   1'b0, 7,  0, 0));
      vt.push_back(mk(3'd1, 30'd5,          30'd3,          30'd2,          1'b0, 10, 0, 0));
      vt.push_back(mk(3'd2, 30'h0F0F0F0F,   30'h00FF00FF,   30'h000F000F,   1'b0, 16, 3, 6));
      vt.push_back(mk(3'd0, 30'h12345678,   30'h01111111,   30'h13456789,   1'b0, 12, 1, 0));
`ifdef ARITH_CTRL_MUL_EN
      vt.push_back(mk(3'd3, 30'h20000000,   30'h20000000,   30'h10000000,   1'b0, 67, 0, 0));
      vt.push_back(mk(3'd3, 30'h3FFFFFFF,   30'h3FFFFFFF,   30'h3FFFFFFE,   1'b0, 67, 0, 0));
`endif

      reset = 1'b1; start_from_op = 1'b0; op_kind_from_op = 3'd0;
      @(negedge clk);
      chk("reset_outs", 32'(all_outs), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy_to_op), 32'd0);

      foreach (vt[i]) run_op(vt[i]);

      run_illegal(3'd5);
      run_illegal(3'd7);
`ifndef ARITH_CTRL_MUL_EN
      run_illegal(3'd3);
`endif

      // stray ack in IDLE must do nothing
      stray_ack = 1'b1;
      #1;
      chk("stray_mem_to_c", 32'(do_mem_to_c_to_au), 32'd0);
      @(negedge clk);
      stray_ack = 1'b0;
      chk("stray_busy", 32'(busy_to_op), 32'd0);
      chk("stray_req", 32'({mem_rd_req_to_mem, mem_wr_req_to_mem}), 32'd0);

      // reset in the middle of a command
      op1 = 30'h3FFFFFFF; op2 = 30'h3FFFFFFF;
`ifdef ARITH_CTRL_MUL_EN
      op_kind_from_op = 3'd3; ack_dly = 0;
`else
      op_kind_from_op = 3'd0; ack_dly = 3;
`endif
      n = shifts;
      start_from_op = 1'b1;
      @(negedge clk);
      start_from_op = 1'b0;
`ifdef ARITH_CTRL_MUL_EN
      begin
         int k;
         k = 0;
         while ((shifts - n) < 10 && k < 200) begin @(negedge clk); k++; end
         if (k >= 200) bad("rst_wait_timeout");
      end
`else
      repeat (3) @(negedge clk);
      chk("rst_req_pending", 32'(mem_rd_req_to_mem), 32'd1);
`endif
      reset = 1'b1;
      #1;
      chk("rst_mid_outs", 32'(all_outs), 32'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_op(mk(3'd0, 30'd5, 30'd3, 30'd8, 1'b0, 9, 0, 0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
